crypt_cmd_ctrl: RTL and testbench

UART command sequencer for the lab-4 cipher datapath. Parses the byte stream arriving from the UART receiver and drives the cipher core; `L` loads a key, `E` encrypts text, `D` decrypts hex. Results are formatted back to the UART transmitter as ASCII. An input FIFO absorbs back-to-back received bytes while the datapath or transmitter is busy.

---
 rtl/crypt_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_crypt_cmd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/crypt_cmd_ctrl.sv
// crypt_cmd_ctrl: UART command sequencer for the cipher core; define CRYPT_CMD_ERR_EN for '?' error replies
module crypt_cmd_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int KEY_W      = 32
) (
  input  logic             clk12m,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_rdy,
  output logic [7:0]       tx_data,
  output logic             tx_data_rdy,
  input  logic             tx_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_load,
  output logic             dp_start,
  output logic             dp_mode,
  output logic [7:0]       dp_din,
  input  logic [7:0]       dp_dout,
  input  logic             dp_done,
  output logic [4:0]       status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {
    IDLE, LOAD, ENC, ENC_RUN, ENC_HI, ENC_LO, DEC_HI, DEC_LO, DEC_RUN, DEC_TX, EOL_CR, EOL_LF, ERR
  } state_t;
  state_t           state_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             ovf_q, key_valid_q, key_load_q, dp_start_q, dp_mode_q, cr_seen_q;
  logic [7:0]       dp_din_q, res_q, head, tx_byte;
  logic [KEY_W-1:0] acc_q, key_q;
  logic [3:0]       hi_q, nib, res_nib;
  logic             empty, full, can_pop, pop, push, is_cr, is_lf, is_hex, emit, err_emit, busy;
  logic [1:0]       mode;
  // FIFO flags, head-byte decode, pop/push decisions and the byte each emitting state sends
  always_comb begin
    empty    = wr_q == rd_q;
    full     = (wr_q - rd_q) == (AW+1)'(FIFO_DEPTH);
    head     = mem_q[rd_q[AW-1:0]];
    is_cr    = head == 8'h0d;
    is_lf    = head == 8'h0a;
    is_hex   = (head >= "0" && head <= "9") || (head >= "a" && head <= "f") || (head >= "A" && head <= "F");
    nib      = head <= "9" ? head[3:0] : head[3:0] + 4'd9;
    can_pop  = state_q inside {IDLE, LOAD, ENC, DEC_HI, DEC_LO} || (state_q == ERR && !cr_seen_q);
    pop      = can_pop && !empty;
    push     = rx_data_rdy && (!full || pop);
`ifdef CRYPT_CMD_ERR_EN
    err_emit = state_q == ERR && cr_seen_q;
`else
    err_emit = 1'b0;
`endif
    emit     = state_q inside {ENC_HI, ENC_LO, DEC_TX, EOL_CR, EOL_LF} || err_emit;
    res_nib  = state_q == ENC_HI ? res_q[7:4] : res_q[3:0];
    tx_byte  = state_q inside {ENC_HI, ENC_LO} ? (res_nib < 4'd10 ? 8'h30 + {4'd0, res_nib} : 8'h57 + {4'd0, res_nib}) :
               state_q == DEC_TX ? res_q : state_q == EOL_CR ? 8'h0d : state_q == EOL_LF ? 8'h0a :
               state_q == ERR ? 8'h3f : 8'h00;
    busy     = state_q != IDLE || !empty;
    mode     = state_q == ERR ? 2'b11 : state_q inside {ENC, ENC_RUN, ENC_HI, ENC_LO} ? 2'b01 :
               state_q inside {DEC_HI, DEC_LO, DEC_RUN, DEC_TX} ? 2'b10 : 2'b00;
  end
  // FIFO storage; a push while full only happens alongside a pop, so the slot is already free
  always_ff @(posedge clk12m) begin
    if (push) mem_q[wr_q[AW-1:0]] <= rx_data;
  end
  // FIFO pointers and the sticky overflow flag
  always_ff @(posedge clk12m) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (rx_data_rdy && !push) ovf_q <= 1'b1;
    end
  end
  // command FSM with registered datapath and key outputs
  always_ff @(posedge clk12m) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_load_q  <= 1'b0;
      dp_start_q  <= 1'b0;
      dp_mode_q   <= 1'b0;
      dp_din_q    <= 8'h00;
      res_q       <= 8'h00;
      hi_q        <= 4'h0;
      cr_seen_q   <= 1'b0;
    end else begin
      key_load_q <= 1'b0;
      dp_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          acc_q     <= '0;
          cr_seen_q <= 1'b0;
          if (pop && !is_lf && !is_cr)
            state_q <= head == "L" ? LOAD : head == "E" ? ENC : head == "D" ? DEC_HI : ERR;
        end
        LOAD: if (pop && !is_lf) begin
          if (is_cr) begin
            key_q       <= acc_q;
            key_load_q  <= 1'b1;
            key_valid_q <= 1'b1;
            state_q     <= EOL_CR;
          end else if (is_hex) acc_q <= KEY_W'({acc_q, nib});
          else state_q <= ERR;
        end
        ENC: if (pop && !is_lf) begin
          if (is_cr) state_q <= EOL_CR;
          else begin
            dp_din_q   <= head;
            dp_mode_q  <= 1'b0;
            dp_start_q <= 1'b1;
            state_q    <= ENC_RUN;
          end
        end
        ENC_RUN: if (dp_done) begin
          res_q   <= dp_dout;
          state_q <= ENC_HI;
        end
        ENC_HI: if (tx_ready) state_q <= ENC_LO;
        ENC_LO: if (tx_ready) state_q <= ENC;
        DEC_HI: if (pop && !is_lf) begin
          hi_q    <= nib;
          state_q <= is_cr ? EOL_CR : is_hex ? DEC_LO : ERR;
        end
        DEC_LO: if (pop && !is_lf) begin
          if (is_cr) state_q <= EOL_CR;
          else if (is_hex) begin
            dp_din_q   <= {hi_q, nib};
            dp_mode_q  <= 1'b1;
            dp_start_q <= 1'b1;
            state_q    <= DEC_RUN;
          end else state_q <= ERR;
        end
        DEC_RUN: if (dp_done) begin
          res_q   <= dp_dout;
          state_q <= DEC_TX;
        end
        DEC_TX: if (tx_ready) state_q <= DEC_HI;
        EOL_CR: if (tx_ready) state_q <= EOL_LF;
        EOL_LF: if (tx_ready) state_q <= IDLE;
`ifdef CRYPT_CMD_ERR_EN
        ERR: begin
          if (cr_seen_q && tx_ready) state_q <= EOL_CR;
          if (pop && is_cr) cr_seen_q <= 1'b1;
        end
`else
        ERR: if (pop && is_cr) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign tx_data     = emit ? tx_byte : 8'h00;
  assign tx_data_rdy = emit && tx_ready;
  assign key         = key_q;
  assign key_load    = key_load_q;
  assign dp_start    = dp_start_q;
  assign dp_mode     = dp_mode_q;
  assign dp_din      = dp_din_q;
  assign status      = {ovf_q, busy, key_valid_q, mode};
endmodule

// File: tb/tb_crypt_cmd_ctrl.sv
// tb_crypt_cmd_ctrl: scoreboard bench for crypt_cmd_ctrl with a 3-cycle XOR cipher stub
module tb_crypt_cmd_ctrl;
  localparam int DEPTH = 16;
  logic        clk, rst_n, rx_data_rdy, tx_data_rdy, tx_ready, key_load, dp_start, dp_mode, dp_done;
  logic [7:0]  rx_data, tx_data, dp_din, dp_dout;
  logic [31:0] key;
  logic [4:0]  status;
  logic [7:0]  txq[$];
  logic [8:0]  dpq[$];
  logic [31:0] kq[$];
  int checks = 0, errors = 0;

  crypt_cmd_ctrl #(.FIFO_DEPTH(DEPTH), .KEY_W(32)) dut (
    .clk12m(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .tx_ready(tx_ready),
    .key(key), .key_load(key_load), .dp_start(dp_start), .dp_mode(dp_mode),
    .dp_din(dp_din), .dp_dout(dp_dout), .dp_done(dp_done), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return n < 10 ? 8'h30 + 8'(n) : 8'h61 + 8'(n) - 8'd10;
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((status[3] || txq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 2000), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_txq"}, 64'(txq.size()), 64'd0);
    chk({tag, "_dpq"}, 64'(dpq.size()), 64'd0);
    chk({tag, "_kq"}, 64'(kq.size()), 64'd0);
  endtask

  // transmit and key-load monitor
  always @(negedge clk) begin
    if (tx_data_rdy) begin
      if (txq.size() == 0) chk("tx_unexpected", 64'(tx_data), 64'h100);
      else chk("tx_byte", 64'(tx_data), 64'(txq.pop_front()));
    end
    if (key_load) begin
      if (kq.size() == 0) chk("key_load_unexpected", 64'(key), 64'h1_0000_0000);
      else chk("key_value", 64'(key), 64'(kq.pop_front()));
      chk("key_valid_at_load", 64'(status[2]), 64'd1);
    end
  end

  // cipher core stub: dout = din ^ 0x78, dp_done three cycles after dp_start
  initial begin
    logic [7:0] r;
    dp_done = 1'b0;
    dp_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (dp_start) begin
        if (dpq.size() == 0) chk("dp_unexpected", 64'({dp_mode, dp_din}), 64'h200);
        else chk("dp_op", 64'({dp_mode, dp_din}), 64'(dpq.pop_front()));
        r = dp_din ^ 8'h78;
        repeat (3) @(posedge clk);
        #1;
        dp_done = 1'b1;
        dp_dout = r;
        @(posedge clk); #1;
        dp_done = 1'b0;
      end
    end
  end

  initial begin
    string enc_s;
    logic [7:0] r;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_data_rdy = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_rdy", 64'(tx_data_rdy), 64'd0);
    chk("rst_key", 64'(key), 64'd0);
    chk("rst_dp", 64'({key_load, dp_start, dp_mode, dp_din}), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    rst_n = 1'b1;
    tx_ready = 1'b1;

    kq.push_back(32'h12345678);
    txq.push_back(8'h0d); txq.push_back(8'h0a);
    send_str("L12345678");
    send(8'h0d);
    wait_idle("load");
    chk("load_key", 64'(key), 64'h12345678);
    chk("load_status", 64'(status), 64'b00100);

    enc_s = "abcd!";
    for (int i = 0; i < enc_s.len(); i++) begin
      dpq.push_back({1'b0, enc_s[i]});
      r = enc_s[i] ^ 8'h78;
      txq.push_back(hexc(r[7:4]));
      txq.push_back(hexc(r[3:0]));
    end
    txq.push_back(8'h0d); txq.push_back(8'h0a);
    send("E");
    @(posedge clk); #1;
    chk("enc_mode", 64'(status[1:0]), 64'd1);
    send_str(enc_s);
    send(8'h0d);
    wait_idle("enc");

    dpq.push_back(9'h119); dpq.push_back(9'h159);
    txq.push_back(8'h61); txq.push_back(8'h21); txq.push_back(8'h0d); txq.push_back(8'h0a);
    send_str("D1959");
    send(8'h0d);
    wait_idle("dec_even");
    dpq.push_back(9'h119);
    txq.push_back(8'h61); txq.push_back(8'h0d); txq.push_back(8'h0a);
    send_str("D195");
    send(8'h0d);
    wait_idle("dec_odd");

`ifdef CRYPT_CMD_ERR_EN
    txq.push_back(8'h3f); txq.push_back(8'h0d); txq.push_back(8'h0a);
`endif
    send("X");
    @(posedge clk); #1;
    chk("err_mode", 64'(status[1:0]), 64'd3);
    send(8'h0d);
    wait_idle("err_x");
`ifdef CRYPT_CMD_ERR_EN
    txq.push_back(8'h3f); txq.push_back(8'h0d); txq.push_back(8'h0a);
`endif
    send_str("L12G");
    send(8'h0d);
    wait_idle("err_load");
    chk("err_key_kept", 64'(key), 64'h12345678);

    tx_ready = 1'b0;
    dpq.push_back({1'b0, 8'h61});
    send("E");
    for (int i = 0; i <= DEPTH; i++) send(8'h61 + 8'(i));
    chk("full_no_ovf", 64'(status[4]), 64'd0);
    send("z");
    chk("ovf_status", 64'(status), 64'b11101);
    repeat (5) @(negedge clk);
    chk("ovf_stalled", 64'({tx_data_rdy, status[1:0]}), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ovf_rst_status", 64'(status), 64'd0);
    chk("ovf_rst_dpq", 64'(dpq.size()), 64'd0);

    tx_ready = 1'b1;
    dpq.push_back({1'b0, 8'h61});
    send("E");
    send("a");
    @(posedge clk); #1;
    chk("run_mode", 64'(status[1:0]), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_tx", 64'({tx_data_rdy, tx_data}), 64'd0);
    chk("mid_rst_dp", 64'({key_load, dp_start, dp_mode, dp_din}), 64'd0);
    chk("mid_rst_key_status", 64'({key, status}), 64'd0);
    repeat (8) @(posedge clk);
    kq.push_back(32'h000000ab);
    txq.push_back(8'h0d); txq.push_back(8'h0a);
    send_str("Lab");
    send(8'h0d);
    wait_idle("post_rst");
    chk("post_rst_key", 64'(key), 64'hab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
